// File: rtl/ym_audio_pkg.sv
// Shared definitions for the YM floating-point DAC word format, used by both
// the serializer and deserializer sides.
package ym_audio_pkg;

    localparam int WORD_BITS   = 13;
    localparam int SAMPLE_BITS = 16;

    // Word layout: {sign, mantissa[8:0], exponent[2:0]}; sign=1 means positive.
    localparam int SIGN_POS = 12;
    localparam int MANT_MSB = 11;
    localparam int MANT_LSB = 3;
    localparam int EXP_MSB  = 2;
    localparam int EXP_LSB  = 0;

    typedef logic [WORD_BITS-1:0]   word_t;
    typedef logic [SAMPLE_BITS-1:0] sample_t;

endpackage

// File: rtl/ym_float_expand.sv
// Combinational expansion of a 13-bit YM float word into a 16-bit two's
// complement sample; exponent 0 is treated as 1 and flagged.
module ym_float_expand
    import ym_audio_pkg::*;
(
    input  word_t   word,
    output sample_t sample,
    output logic    exp_zero
);

    logic [2:0]  expo;
    logic [2:0]  shamt;
    logic [14:0] field;

    always_comb begin
        expo     = word[EXP_MSB:EXP_LSB];
        exp_zero = (expo == 3'd0);
        shamt    = exp_zero ? 3'd0 : expo - 3'd1;
        field    = {6'b0, word[MANT_MSB:MANT_LSB]} << shamt;
        // Negative values are stored as the ones' complement of the magnitude field.
        if (!word[SIGN_POS]) begin
            field = ~field;
        end
        sample = {~word[SIGN_POS], field};
    end

endmodule

// File: rtl/ym_dac_deser.sv
// Deserializer for the YM DAC serial float stream: shifts bits, latches a word on
// each SH1/SH2 falling edge and emits decoded left/right samples two clocks later.
module ym_dac_deser
    import ym_audio_pkg::*;
#(
    parameter int MIN_BITS = 13
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    bit_en,
    input  logic    ser_data,
    input  logic    sh1,
    input  logic    sh2,
    output sample_t left_out,
    output sample_t right_out,
    output logic    left_valid,
    output logic    right_valid,
    output logic    frame_err
);

    logic [15:0] sr;
    logic [15:0] sr_next;
    logic [4:0]  bit_cnt;
    logic [5:0]  cnt_at_e;
    logic        sh1_q, sh2_q;
    logic        sh1_fall, sh2_fall, any_fall;
    logic        word_ok;

    word_t       word_q;
    logic        left_pend, right_pend;
    sample_t     dec_sample;
    logic        dec_exp_zero;

    always_comb begin
        sr_next  = bit_en ? ((sr << 1) | 16'(ser_data)) : sr;
        sh1_fall = sh1_q & ~sh1;
        sh2_fall = sh2_q & ~sh2;
        any_fall = sh1_fall | sh2_fall;
        // A bit arriving on the strobe edge itself belongs to the word being latched.
        cnt_at_e = {1'b0, bit_cnt} + {5'b0, bit_en};
        word_ok  = (cnt_at_e >= 6'(MIN_BITS));
    end

    ym_float_expand u_expand (
        .word     (word_q),
        .sample   (dec_sample),
        .exp_zero (dec_exp_zero)
    );

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and checked first, so it overrides every
        // update below in the same cycle, including a pending pipeline stage.
        if (reset) begin
            sr          <= '0;
            bit_cnt     <= '0;
            sh1_q       <= 1'b0;
            sh2_q       <= 1'b0;
            word_q      <= '0;
            left_pend   <= 1'b0;
            right_pend  <= 1'b0;
            left_out    <= '0;
            right_out   <= '0;
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sr    <= sr_next;
            sh1_q <= sh1;
            sh2_q <= sh2;

            if (any_fall) begin
                bit_cnt <= {4'b0, bit_en};
            end else if (bit_en && bit_cnt != 5'd31) begin
                bit_cnt <= bit_cnt + 5'd1;
            end

            // Stage E: capture the word and which channels accept it.
            if (any_fall) begin
                word_q <= word_t'(sr_next);
            end
            left_pend  <= sh1_fall & word_ok;
            right_pend <= sh2_fall & word_ok;

            // Stage E+1: decode once, fan out to whichever channels are pending.
            left_valid  <= left_pend;
            right_valid <= right_pend;
            if (left_pend) begin
                left_out <= dec_sample;
            end
            if (right_pend) begin
                right_out <= dec_sample;
            end

            if ((any_fall && !word_ok) || ((left_pend || right_pend) && dec_exp_zero)) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ym_dac_deser.sv
// Directed, table-driven bench for ym_dac_deser with hand-decoded expected samples.
module tb_ym_dac_deser;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_en;
    logic        ser_data;
    logic        sh1;
    logic        sh2;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        left_valid;
    logic        right_valid;
    logic        frame_err;

    int tests = 0;
    int fails = 0;

    ym_dac_deser #(.MIN_BITS(13)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_en      (bit_en),
        .ser_data    (ser_data),
        .sh1         (sh1),
        .sh2         (sh2),
        .left_out    (left_out),
        .right_out   (right_out),
        .left_valid  (left_valid),
        .right_valid (right_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] word;
        logic        s1;
        logic        s2;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bit_en   = 1'b0;
        ser_data = 1'b0;
        sh1      = 1'b0;
        sh2      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic shift_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_en   = 1'b1;
            ser_data = bits[i];
            tick();
        end
        bit_en   = 1'b0;
        ser_data = 1'b0;
    endtask

    initial begin
        vecs[0] = '{13'h191D, 1'b1, 1'b0, 16'h1230, 16'h0000, 1'b0};
        vecs[1] = '{13'h091D, 1'b0, 1'b1, 16'h0000, 16'hEDCF, 1'b0};
        vecs[2] = '{13'h1FFF, 1'b1, 1'b0, 16'h7FC0, 16'h0000, 1'b0};
        vecs[3] = '{13'h191D, 1'b1, 1'b1, 16'h1230, 16'h1230, 1'b0};
        vecs[4] = '{13'h1918, 1'b1, 1'b0, 16'h0123, 16'h0000, 1'b1};
        vecs[5] = '{13'h0000, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1};
        vecs[6] = '{13'h1FF9, 1'b1, 1'b0, 16'h01FF, 16'h0000, 1'b0};
        vecs[7] = '{13'h0FF9, 1'b0, 1'b1, 16'h0000, 16'hFE00, 1'b0};

        do_reset();
        check("reset_left_out",  left_out,  16'h0000);
        check("reset_right_out", right_out, 16'h0000);
        check("reset_valids",    16'({left_valid, right_valid}), 16'h0);
        check("reset_err",       16'(frame_err), 16'h0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            sh1 = vecs[v].s1;
            sh2 = vecs[v].s2;
            shift_bits({3'b000, vecs[v].word}, 16);
            sh1 = 1'b0;
            sh2 = 1'b0;
            tick();
            check($sformatf("v%0d_valid_at_e", v), 16'({left_valid, right_valid}), 16'h0);
            tick();
            check($sformatf("v%0d_left_out", v),    left_out,  vecs[v].exp_l);
            check($sformatf("v%0d_right_out", v),   right_out, vecs[v].exp_r);
            check($sformatf("v%0d_left_valid", v),  16'(left_valid),  16'(vecs[v].s1));
            check($sformatf("v%0d_right_valid", v), 16'(right_valid), 16'(vecs[v].s2));
            check($sformatf("v%0d_frame_err", v),   16'(frame_err),   16'(vecs[v].exp_err));
            tick();
            check($sformatf("v%0d_valid_pulse_end", v), 16'({left_valid, right_valid}), 16'h0);
        end

        // Short word after a good one: error flag, output held, no pulse, sticky.
        do_reset();
        sh1 = 1'b1;
        shift_bits(16'h191D, 16);
        sh1 = 1'b0;
        tick();
        tick();
        check("short_pre_left", left_out, 16'h1230);
        sh1 = 1'b1;
        shift_bits(16'h00AA, 8);
        sh1 = 1'b0;
        tick();
        tick();
        check("short_valid",    16'(left_valid), 16'h0);
        check("short_left_out", left_out, 16'h1230);
        check("short_err",      16'(frame_err), 16'h1);
        tick();
        check("short_valid_late", 16'(left_valid), 16'h0);
        shift_bits(16'hFFFF, 16);
        check("short_err_sticky", 16'(frame_err), 16'h1);
        do_reset();
        check("short_err_cleared", 16'(frame_err), 16'h0);

        // Reset one cycle after the strobe edge kills the in-flight word.
        do_reset();
        sh1 = 1'b1;
        shift_bits(16'h191D, 16);
        sh1 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_valid", 16'(left_valid), 16'h0);
        check("rst_mid_left",  left_out, 16'h0000);
        reset = 1'b0;
        tick();
        check("rst_mid_valid_after", 16'(left_valid), 16'h0);
        check("rst_mid_left_after",  left_out, 16'h0000);

        // Strobe held high through reset, falling afterwards, still latches.
        reset = 1'b1;
        sh1   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        shift_bits(16'h191D, 16);
        sh1 = 1'b0;
        tick();
        tick();
        check("sh_hi_rst_valid", 16'(left_valid), 16'h1);
        check("sh_hi_rst_left",  left_out, 16'h1230);

        // Last bit arrives on the strobe edge itself and is part of the word.
        do_reset();
        sh2 = 1'b1;
        shift_bits(16'h091D >> 1, 15);
        bit_en   = 1'b1;
        ser_data = 1'b1;
        sh2      = 1'b0;
        tick();
        bit_en   = 1'b0;
        ser_data = 1'b0;
        tick();
        check("edge_bit_valid", 16'(right_valid), 16'h1);
        check("edge_bit_right", right_out, 16'hEDCF);
        check("edge_bit_err",   16'(frame_err), 16'h0);

        // Strobe held low produces no further latches.
        tick();
        tick();
        check("held_low_valid", 16'(right_valid), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ym_dac_deser.md
YM_DAC_DESER -- requirements
Module: ym_dac_deser

Interface
REQ-001 Parameter: MIN_BITS, 13, minimum BIT_EN count since the previous strobe for a word to be accepted.
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RESET  input  1  reset; one clock, synchronous, active-high.
REQ-004 BIT_EN  input  1  serial bit strobe; one CLK-wide pulse per serial bit.
REQ-005 SER_DATA  input  1  serial float stream, MSB first, sampled only when BIT_EN=1.
REQ-006 SH1  input  1  left-channel load strobe, active high; a 1->0 transition latches the word.
REQ-007 SH2  input  1  right-channel load strobe, same rules as SH1.
REQ-008 LEFT_OUT  output  16  reconstructed left sample, two's complement.
REQ-009 RIGHT_OUT  output  16  reconstructed right sample, two's complement.
REQ-010 LEFT_VALID  output  1  one-cycle pulse when LEFT_OUT updates.
REQ-011 RIGHT_VALID  output  1  one-cycle pulse when RIGHT_OUT updates.
REQ-012 FRAME_ERR  output  1  sticky error flag, cleared only by RESET.

Function
REQ-013 Shift register SHALL be 16 bits; on BIT_EN=1 it loads {SR[14:0], SER_DATA}.
REQ-014 Bit counter SHALL increment on BIT_EN, saturate at 31, and load 0 on a strobe falling edge, or 1 if BIT_EN is also high that cycle.
REQ-015 Falling edge is detected when the registered previous strobe value is 1 and the current sample is 0; cycle E is the CLK edge where this occurs.
REQ-016 The captured word SHALL be SR[12:0] including any bit shifted at cycle E: M=word[12:3] (M[9]=sign, 1=positive), X=word[2:0] exponent.
REQ-017 Decode: P = M[8:0] shifted left by (X-1) into a 15-bit field, zeros below; if M[9]=0, invert all 15 bits; output = {~M[9], field}.
REQ-018 X=0 SHALL decode as X=1 and set FRAME_ERR.
REQ-019 A word with bit count < MIN_BITS at cycle E SHALL set FRAME_ERR, leave the output unchanged, and produce no VALID pulse.
REQ-020 Pipeline: word and channel flags registered at E; decoded output and VALID registered at E+1; outputs visible after the E+1 edge; latency 2 clocks from the strobe sample.
REQ-021 Simultaneous SH1 and SH2 falling edges SHALL latch the same word into both channels, with both VALIDs pulsing together.
REQ-022 A strobe held low or high produces no further latches; back-to-back edges every 2 cycles SHALL each produce a VALID.
REQ-023 No bits are dropped: shifting continues during all pipeline stages.

Reset
REQ-024 On RESET: SR=0, counter=0, previous-strobe registers=0, pipeline cleared, LEFT_OUT=RIGHT_OUT=16'h0000, VALIDs=0, FRAME_ERR=0.
REQ-025 RESET mid-word or mid-pipeline SHALL discard the in-flight word; no VALID pulse follows RESET.
REQ-026 A strobe that is high during RESET and falls after RESET deasserts SHALL produce a latch.

Structure
REQ-027 Package ym_audio_pkg SHALL hold WORD_BITS=13, field positions for the mantissa, sign and exponent, and the 16-bit sample typedef, shared with the serializer side.
REQ-028 Combinational sub-module ym_float_expand (13-bit word in, 16-bit sample plus exponent-zero flag out) SHALL be instantiated once and muxed per channel at stage E+1.

Verification
REQ-029 Shift 16 bits ending in 13'h191D, then a SH1 falling edge -> LEFT_OUT=16'h1230, LEFT_VALID pulses for 1 cycle 2 clocks after the edge, FRAME_ERR=0.
REQ-030 Word 13'h091D on SH2 -> RIGHT_OUT=16'hEDCF; word 13'h1FFF -> 16'h7FC0.
REQ-031 Word 13'h191D with SH1 and SH2 falling in the same cycle -> both outputs = 16'h1230, both VALIDs pulse together.
REQ-032 Only 8 BIT_EN pulses, then a SH1 fall -> FRAME_ERR=1, LEFT_OUT unchanged, no LEFT_VALID; FRAME_ERR stays high until RESET.
REQ-033 Word with X=0 (13'h1918) -> LEFT_OUT=16'h0123, FRAME_ERR=1.
REQ-034 RESET asserted 1 cycle after a SH1 fall -> no LEFT_VALID, all outputs 0 the following cycle.
